leitor_display_7seg: RTL and testbench
======================================

// Module: leitor_display_7seg
// PURPOSE
//  Recovers BCD digits from a multiplexed, active-low 7-segment display bus driven by an external board.
//  It is the inverse of the BCD-to-7-segment decoder used in our display path.
//  Synchronises the bus, filters scan glitches, maps segment patterns back to BCD and assembles per-scan frames.
//  Frames are delivered through a valid/ready handshake to the checker logic.
// PARAMETERS
//  NUM_DIGITOS     4   digits on the bus (>=1)
//  ESTAVEL_CICLOS  8   consecutive identical samples required before capture (>=2)
// PORTS
//  clk            in   1              system clock; everything is on the rising edge
//  rst_n          in   1              asynchronous, active-low reset
//  seg_a..seg_g   in   1 each         segment lines, active-low (0 = lit), asynchronous to clk
//  anodo_n        in   NUM_DIGITOS    digit enables, active-low, one-hot while scanning
//  digitos        out  4*NUM_DIGITOS  frame: digit i at [4i+3:4i]
//  erro_segmento  out  NUM_DIGITOS    bit i set = digit i pattern was not 0-9
//  quadro_valido  out  1              frame held on digitos/erro_segmento
//  quadro_pronto  in   1              consumer accepts the frame
//  perda_quadro   out  1              1-cycle pulse: a completed frame was discarded
//  erro_anodo     out  1              1-cycle pulse: stable word with >1 anode low
// BEHAVIOUR
//  Reset (async, any time): all outputs 0; capture mask 0; FSM = ESPERA; counter 0.
//   Sync flops reset to all-ones, i.e. a blank bus.
//  Sync: 2-flop synchroniser on W = {anodo_n, a,b,c,d,e,f,g}.
//   s2 = synchronised word; s3 = s2 delayed by one cycle.
//  FSM:
//   ESPERA    -> FILTRANDO when s2 != s3; counter <= 0.
//   FILTRANDO:
//    - s2 != s3: counter <= 0.
//    - otherwise counter++.
//    - counter == ESTAVEL_CICLOS-2 with s2 == s3: act on the word; go to CAPTURADO.
//   CAPTURADO -> FILTRANDO when s2 != s3; counter <= 0. Never captures the same word twice.
//  Acting on a stable word:
//   - all anodes high: ignored.
//   - >1 anode low: erro_anodo pulses; nothing stored.
//   - exactly anode i low: decode into digit slot i and set mask[i].
//  Latency: a pin change held steady is captured on edge 2+ESTAVEL_CICLOS after the change.
//  Decode, {a..g} -> BCD:
//   01->0  4F->1  12->2  06->3  4C->4  24->5  20->6  0F->7  00->8  04->9
//   any other pattern -> 4'hF, with erro flag set for that slot.
//  Re-capturing slot i before the frame completes overwrites it.
//  Frame complete: the edge on which the mask becomes all-ones. Mask clears on that same edge.
//   - quadro_valido=0, or quadro_pronto=1 on that edge: load outputs from slots; quadro_valido=1.
//   - otherwise: frame discarded; held frame unchanged; perda_quadro pulses.
//  Handshake:
//   - transfer = quadro_valido & quadro_pronto.
//   - transfer alone clears quadro_valido on the next edge.
//   - transfer plus frame completion on the same edge: new frame loaded, quadro_valido stays 1.
//   - digitos and erro_segmento are stable while quadro_valido=1 and not transferred.
// TESTING
//  1. Reset mid-FILTRANDO -> all outputs 0 immediately; no capture for at least 2+ESTAVEL_CICLOS edges after release.
//  2. 4 digits scanned 1,2,3,4 (patterns 4F,12,06,4C), each held 20 cycles, pronto=1 ->
//     quadro_valido rises, digitos=16'h4321, erro_segmento=0.
//  3. Digit 2 pattern 7F (blank) -> digit 2 = F and erro_segmento=4'b0100.
//     A 5-cycle glitch (< ESTAVEL_CICLOS) on any line -> no capture and no change to the frame.
//  4. pronto=0 while two frames complete -> first frame held; perda_quadro pulses exactly once.
//     Then pronto=1 -> one transfer; quadro_valido falls.
//  5. anodo_n=4'b1100 held 20 cycles -> one erro_anodo pulse; mask and frame unchanged.
//  6. pronto=1 on the very edge a frame completes -> new frame loaded, quadro_valido stays 1, no perda_quadro.

Source files
------------

// File: rtl/leitor_display_7seg.sv
// Recovers BCD digits from a multiplexed, active-low 7-segment bus and
// assembles per-scan frames delivered over a valid/ready handshake.
module leitor_display_7seg #(
  parameter int unsigned NUM_DIGITOS    = 4,
  parameter int unsigned ESTAVEL_CICLOS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       seg_a,
  input  logic                       seg_b,
  input  logic                       seg_c,
  input  logic                       seg_d,
  input  logic                       seg_e,
  input  logic                       seg_f,
  input  logic                       seg_g,
  input  logic [NUM_DIGITOS-1:0]     anodo_n,
  output logic [4*NUM_DIGITOS-1:0]   digitos,
  output logic [NUM_DIGITOS-1:0]     erro_segmento,
  output logic                       quadro_valido,
  input  logic                       quadro_pronto,
  output logic                       perda_quadro,
  output logic                       erro_anodo
);

  localparam int unsigned W  = NUM_DIGITOS + 7;
  localparam int unsigned CW = (ESTAVEL_CICLOS > 2) ? $clog2(ESTAVEL_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(ESTAVEL_CICLOS - 2);

  typedef enum logic [1:0] {Espera, Filtrando, Capturado} estado_t;

  // Synchroniser; all-ones is a blank bus
  logic [W-1:0] w_bus;
  logic [W-1:0] r_sync1, r_sync2, r_sync3;

  assign w_bus = {anodo_n, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_sync3 <= '1;
    end else begin
      r_sync1 <= w_bus;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Stability filter
  estado_t       r_estado, w_estado_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic          w_mudou;
  logic          w_captura;

  assign w_mudou = (r_sync2 != r_sync3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= Espera;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_estado_d;
      r_cnt    <= w_cnt_d;
    end
  end

  always_comb begin
    w_estado_d = r_estado;
    w_cnt_d    = r_cnt;
    w_captura  = 1'b0;
    unique case (r_estado)
      Espera, Capturado: begin
        if (w_mudou) begin
          w_estado_d = Filtrando;
          w_cnt_d    = '0;
        end
      end
      Filtrando: begin
        if (w_mudou) begin
          w_cnt_d = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_captura  = 1'b1;
          w_estado_d = Capturado;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      default: begin
        w_estado_d = Espera;
        w_cnt_d    = '0;
      end
    endcase
  end

  // Word classification and decode
  logic [NUM_DIGITOS-1:0] w_ativos;
  logic [6:0]             w_seg;
  logic                   w_nenhum, w_multiplo;
  logic [NUM_DIGITOS-1:0] w_bit_novo;
  logic [3:0]             w_bcd;
  logic                   w_invalido;

  assign w_ativos   = ~r_sync2[W-1:7];
  assign w_seg      = r_sync2[6:0];
  assign w_nenhum   = (w_ativos == '0);
  assign w_multiplo = ((w_ativos & (w_ativos - NUM_DIGITOS'(1))) != '0);
  assign w_bit_novo = (w_captura && !w_nenhum && !w_multiplo) ? w_ativos : '0;

  always_comb begin
    w_bcd      = 4'hF;
    w_invalido = 1'b0;
    case (w_seg)
      7'h01:   w_bcd = 4'd0;
      7'h4F:   w_bcd = 4'd1;
      7'h12:   w_bcd = 4'd2;
      7'h06:   w_bcd = 4'd3;
      7'h4C:   w_bcd = 4'd4;
      7'h24:   w_bcd = 4'd5;
      7'h20:   w_bcd = 4'd6;
      7'h0F:   w_bcd = 4'd7;
      7'h00:   w_bcd = 4'd8;
      7'h04:   w_bcd = 4'd9;
      default: w_invalido = 1'b1;
    endcase
  end

  // Digit slots and capture mask
  logic [NUM_DIGITOS-1:0][3:0] r_slot, w_slot_d;
  logic [NUM_DIGITOS-1:0]      r_slot_err, w_slot_err_d;
  logic [NUM_DIGITOS-1:0]      r_mask, w_mask_or, w_mask_d;
  logic                        w_completo;

  always_comb begin
    w_slot_d     = r_slot;
    w_slot_err_d = r_slot_err;
    for (int i = 0; i < int'(NUM_DIGITOS); i++) begin
      if (w_bit_novo[i]) begin
        w_slot_d[i]     = w_bcd;
        w_slot_err_d[i] = w_invalido;
      end
    end
  end

  // The mask is never all-ones while held, so all-ones here means a new frame
  assign w_mask_or  = r_mask | w_bit_novo;
  assign w_completo = &w_mask_or;
  assign w_mask_d   = w_completo ? '0 : w_mask_or;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot     <= '0;
      r_slot_err <= '0;
      r_mask     <= '0;
    end else begin
      r_slot     <= w_slot_d;
      r_slot_err <= w_slot_err_d;
      r_mask     <= w_mask_d;
    end
  end

  // Frame output and handshake
  logic                     r_valido, w_valido_d;
  logic [4*NUM_DIGITOS-1:0] r_digitos, w_digitos_d;
  logic [NUM_DIGITOS-1:0]   r_erro_seg, w_erro_seg_d;
  logic                     r_perda, w_perda_d;
  logic                     r_erro_anodo, w_erro_anodo_d;

  always_comb begin
    w_valido_d     = r_valido;
    w_digitos_d    = r_digitos;
    w_erro_seg_d   = r_erro_seg;
    w_perda_d      = 1'b0;
    w_erro_anodo_d = w_captura && w_multiplo;
    if (w_completo) begin
      if (!r_valido || quadro_pronto) begin
        w_valido_d   = 1'b1;
        w_digitos_d  = w_slot_d;
        w_erro_seg_d = w_slot_err_d;
      end else begin
        w_perda_d = 1'b1;
      end
    end else if (r_valido && quadro_pronto) begin
      w_valido_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valido     <= 1'b0;
      r_digitos    <= '0;
      r_erro_seg   <= '0;
      r_perda      <= 1'b0;
      r_erro_anodo <= 1'b0;
    end else begin
      r_valido     <= w_valido_d;
      r_digitos    <= w_digitos_d;
      r_erro_seg   <= w_erro_seg_d;
      r_perda      <= w_perda_d;
      r_erro_anodo <= w_erro_anodo_d;
    end
  end

  assign digitos       = r_digitos;
  assign erro_segmento = r_erro_seg;
  assign quadro_valido = r_valido;
  assign perda_quadro  = r_perda;
  assign erro_anodo    = r_erro_anodo;

endmodule

// File: tb/tb_leitor_display_7seg.sv
// Bench for leitor_display_7seg: a sample-history reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_leitor_display_7seg;

  localparam int N   = 4;
  localparam int EST = 8;
  localparam int WW  = N + 7;
  localparam logic [6:0] TAB [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                      7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [6:0]   seg = 7'h7F;
  logic [N-1:0] anodo_n = '1;
  logic         pronto = 1'b0;
  logic [4*N-1:0] digitos;
  logic [N-1:0] erro_segmento;
  logic         quadro_valido, perda_quadro, erro_anodo;

  int n_checks = 0;
  int n_fail   = 0;
  int n_perda_dut = 0;
  int n_ea_dut    = 0;
  bit fim = 1'b0;

  leitor_display_7seg #(.NUM_DIGITOS(N), .ESTAVEL_CICLOS(EST)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_a         (seg[6]),
    .seg_b         (seg[5]),
    .seg_c         (seg[4]),
    .seg_d         (seg[3]),
    .seg_e         (seg[2]),
    .seg_f         (seg[1]),
    .seg_g         (seg[0]),
    .anodo_n       (anodo_n),
    .digitos       (digitos),
    .erro_segmento (erro_segmento),
    .quadro_valido (quadro_valido),
    .quadro_pronto (pronto),
    .perda_quadro  (perda_quadro),
    .erro_anodo    (erro_anodo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] dec(input logic [6:0] p);
    for (int v = 0; v < 10; v++) if (TAB[v] == p) return {1'b0, 4'(v)};
    return 5'h1F;
  endfunction

  // Reference model: a word is acted upon the first edge on which the last EST
  // synchronised samples (input two edges back and earlier) are all identical.
  logic [WW-1:0]  hist [EST+3];
  logic [3:0]     m_slot [N];
  logic           m_slot_err [N];
  logic [N-1:0]   m_mask = '0;
  logic           m_valid = 1'b0;
  logic [4*N-1:0] m_dig = '0;
  logic [N-1:0]   m_err = '0;
  logic           m_perda = 1'b0;
  logic           m_ea = 1'b0;

  initial begin
    for (int k = 0; k < EST + 3; k++) hist[k] = '1;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < EST + 3; k++) hist[k] = '1;
        for (int i = 0; i < N; i++) begin
          m_slot[i] = '0;
          m_slot_err[i] = 1'b0;
        end
        m_mask = '0; m_valid = 1'b0; m_dig = '0; m_err = '0;
        m_perda = 1'b0; m_ea = 1'b0;
      end else begin
        bit stable, cap, complete;
        int nlow, idx;
        logic [N-1:0] an;
        logic [4:0] d;
        for (int k = EST + 2; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = {anodo_n, seg};
        stable = 1'b1;
        for (int k = 3; k <= EST + 1; k++) if (hist[k] != hist[2]) stable = 1'b0;
        cap = stable && (hist[EST+2] != hist[2]);
        complete = 1'b0;
        m_perda = 1'b0;
        m_ea = 1'b0;
        if (cap) begin
          an = hist[2][WW-1:7];
          nlow = 0;
          idx = 0;
          for (int i = 0; i < N; i++) if (!an[i]) begin nlow++; idx = i; end
          if (nlow > 1) m_ea = 1'b1;
          else if (nlow == 1) begin
            d = dec(hist[2][6:0]);
            m_slot[idx] = d[3:0];
            m_slot_err[idx] = d[4];
            m_mask[idx] = 1'b1;
            if (m_mask == '1) begin
              complete = 1'b1;
              m_mask = '0;
            end
          end
        end
        if (complete) begin
          if (!m_valid || pronto) begin
            m_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
              m_dig[4*i +: 4] = m_slot[i];
              m_err[i] = m_slot_err[i];
            end
          end else m_perda = 1'b1;
        end else if (m_valid && pronto) m_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!fim) begin
        chk("quadro_valido", 64'(quadro_valido), 64'(m_valid));
        chk("digitos", 64'(digitos), 64'(m_dig));
        chk("erro_segmento", 64'(erro_segmento), 64'(m_err));
        chk("perda_quadro", 64'(perda_quadro), 64'(m_perda));
        chk("erro_anodo", 64'(erro_anodo), 64'(m_ea));
        if (perda_quadro) n_perda_dut++;
        if (erro_anodo) n_ea_dut++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic scan(input int i, input logic [6:0] p, input int n);
    anodo_n = ~(N'(1) << i);
    seg = p;
    repeat (n) tick();
  endtask

  task automatic blank(input int n);
    anodo_n = '1;
    seg = 7'h7F;
    repeat (n) tick();
  endtask

  initial begin
    int base, first;
    repeat (3) tick();
    chk("reset_valido", 64'(quadro_valido), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic frame 1,2,3,4 with consumer ready
    pronto = 1'b1;
    scan(0, 7'h4F, 20);
    scan(1, 7'h12, 20);
    scan(2, 7'h06, 20);
    scan(3, 7'h4C, EST + 2);
    chk("t2_valido", 64'(quadro_valido), 64'd1);
    chk("t2_digitos", 64'(digitos), 64'h4321);
    chk("t2_erro", 64'(erro_segmento), 64'd0);
    scan(3, 7'h4C, 8);

    // Reset in the middle of filtering a multi-anode word
    anodo_n = 4'b1100;
    seg = 7'h00;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("t1_digitos0", 64'(digitos), 64'd0);
    chk("t1_valido0", 64'(quadro_valido), 64'd0);
    chk("t1_erro0", 64'(erro_segmento), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= EST + 4; k++) begin
      tick();
      if (erro_anodo && first == 0) first = k;
    end
    chk("t1_latencia", 64'(first), 64'(EST + 2));
    blank(20);

    // Blank digit 2, then short glitches
    pronto = 1'b0;
    scan(0, 7'h4F, 20);
    scan(1, 7'h12, 20);
    scan(2, 7'h7F, 20);
    scan(3, 7'h4C, 20);
    chk("t3_digitos", 64'(digitos), 64'h4F21);
    chk("t3_erro", 64'(erro_segmento), 64'b0100);
    blank(20);
    base = n_perda_dut;
    anodo_n = 4'b1101;
    seg = 7'h00;
    repeat (5) tick();
    blank(20);
    seg = 7'h3F;
    repeat (5) tick();
    blank(20);
    chk("t3_glitch_digitos", 64'(digitos), 64'h4F21);
    chk("t3_glitch_valido", 64'(quadro_valido), 64'd1);
    chk("t3_glitch_perda", 64'(n_perda_dut - base), 64'd0);

    // Two frames with consumer stalled
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    chk("t4_vazio", 64'(quadro_valido), 64'd0);
    base = n_perda_dut;
    scan(0, 7'h24, 20);
    scan(1, 7'h20, 20);
    scan(2, 7'h0F, 20);
    scan(3, 7'h00, 20);
    scan(0, 7'h04, 20);
    scan(1, 7'h01, 20);
    scan(2, 7'h4F, 20);
    scan(3, 7'h12, 20);
    chk("t4_digitos", 64'(digitos), 64'h8765);
    chk("t4_perdas", 64'(n_perda_dut - base), 64'd1);
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    chk("t4_transfer", 64'(quadro_valido), 64'd0);
    blank(20);

    // Two anodes low
    base = n_ea_dut;
    anodo_n = 4'b1100;
    seg = 7'h00;
    repeat (20) tick();
    blank(20);
    chk("t5_pulsos", 64'(n_ea_dut - base), 64'd1);
    chk("t5_digitos", 64'(digitos), 64'h8765);

    // Transfer and completion on the same edge
    scan(0, 7'h01, 20);
    scan(1, 7'h4F, 20);
    scan(2, 7'h12, 20);
    scan(3, 7'h06, 20);
    chk("t6_primeiro", 64'(digitos), 64'h3210);
    base = n_perda_dut;
    scan(0, 7'h4C, 20);
    scan(1, 7'h24, 20);
    scan(2, 7'h20, 20);
    scan(3, 7'h0F, EST + 1);
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    chk("t6_valido", 64'(quadro_valido), 64'd1);
    chk("t6_digitos", 64'(digitos), 64'h7654);
    chk("t6_perda", 64'(perda_quadro), 64'd0);
    tick();
    chk("t6_perdas", 64'(n_perda_dut - base), 64'd0);

    // Randomised scanning
    for (int it = 0; it < 400; it++) begin
      int r;
      logic [6:0] p;
      r = int'($urandom_range(0, 9));
      pronto = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 4) == 0) ? 7'($urandom) : TAB[$urandom_range(0, 9)];
      if (it == 200) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      if (r < 7) scan(int'($urandom_range(0, N - 1)), p, int'($urandom_range(1, 20)));
      else if (r == 7) begin
        anodo_n = N'($urandom);
        seg = p;
        repeat ($urandom_range(1, 20)) tick();
      end else blank(int'($urandom_range(1, 15)));
    end

    blank(4);
    fim = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
